debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel pushbutton/switch debouncer with per-channel edge strobes and optional hold-to-repeat. It sits directly behind the board I/O pins (btnc/btnu/btnl/btnr/btnd, switches) on the 65 MHz system clock. It replaces per-button single-channel debounce instances and gives the game FSM and board updater one-cycle press/release strobes instead of levels.

## Interface
Parameters:
- CHANNELS, 5, number of independent inputs (≥1)
- DB_COUNT, 1_000_000, consecutive stable cycles required to accept a new level (≥1); ~15.4 ms at 65 MHz
- REPEAT_DELAY, 32_500_000, cycles a held channel waits before its first repeat strobe (≥1); only used with repeat compiled in
- REPEAT_PERIOD, 6_500_000, cycles between subsequent repeat strobes (≥1); only used with repeat compiled in
- CNT_W, $clog2(DB_COUNT+1), debounce counter width (derived; do not override)

Ports:
- clock_in, input, 1, system clock (65 MHz)
- reset_in, input, 1, asynchronous, active-high reset
- noisy_in, input, CHANNELS, raw asynchronous inputs
- clean_out, output, CHANNELS, debounced levels
- rise_out, output, CHANNELS, one-cycle strobe on accepted 0→1 (plus repeat strobes when enabled)
- fall_out, output, CHANNELS, one-cycle strobe on accepted 1→0
- any_out, output, 1, registered OR of clean_out

## Operation
- Per channel: 2-flop synchroniser (s1, s2) → debounce counter → clean register → edge logic. Channels are fully independent; no shared state.
- Debounce: if s2 == clean_out[i], counter clears to 0. If s2 != clean_out[i], counter increments. On the cycle the counter would reach DB_COUNT (i.e., DB_COUNT consecutive mismatching cycles):
  - clean_out[i] takes s2;
  - counter clears;
  - rise_out[i] or fall_out[i] asserts for exactly that cycle.
- Any single-cycle return of s2 to clean_out[i] restarts the count from 0. Glitches shorter than DB_COUNT cycles never reach clean_out.
- Counter never exceeds DB_COUNT-1; no wrap.
- any_out = |clean_out, registered (same cycle as clean_out change).
- Reset (async, any time, including mid-count or mid-repeat):
  - s1, s2, clean_out, counters and repeat state → 0;
  - rise_out, fall_out, any_out → 0.
  - No strobe is emitted on reset release. An input held high through reset produces a rise strobe DB_COUNT+2 cycles after release.

## Timing
- noisy_in change stable before edge k → s2 updates at edge k+1 → clean_out and strobe update at edge k+1+DB_COUNT. Total latency: DB_COUNT+2 edges.
- Strobes are exactly one cycle wide and coincide with the clean_out transition cycle.
- rise_out and fall_out are never both high for the same channel in the same cycle.
- Minimum spacing between opposite strobes on one channel is DB_COUNT cycles.
- Simultaneous transitions on multiple channels strobe independently in the same cycle.

## Configuration
- Macro DEBOUNCE_BANK_REPEAT_EN.
- Defined: per-channel repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
  - While clean_out[i]=1, the counter runs from the accepted rising edge.
  - An extra rise_out[i] strobe fires REPEAT_DELAY cycles after the initial rise strobe, then every REPEAT_PERIOD cycles while the channel stays high.
  - The counter clears when clean_out[i] falls or on reset.
  - fall_out is unaffected.
- Undefined: no repeat logic is synthesised. rise_out strobes only once per accepted 0→1. REPEAT_* parameters are ignored.

## Test plan
Bench parameters: CHANNELS=4, DB_COUNT=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- **Clean press:** noisy_in[0] 0→1 held → clean_out[0]=1 and rise_out[0]=1 for one cycle exactly 10 edges after the change. No other channel moves. any_out rises on the same cycle.
- **Bounce rejection:** noisy_in[1] toggles high for 7 cycles, low 1, high 7, then low → clean_out[1] stays 0 and no strobes occur. Then hold high 8+ cycles → single rise strobe.
- **Release:** after an accepted press, drop noisy_in[0] to 0 → fall_out[0] one-cycle pulse 10 edges later. clean_out[0]=0. any_out=0 if no other channel is high.
- **Simultaneous:** noisy_in 4'b0000→4'b1111 in one cycle → all four rise_out bits assert in the same cycle, 10 edges later.
- **Reset mid-count:** assert reset_in asynchronously (between edges) 5 cycles into a count → all outputs 0 immediately. After release with input still high → rise strobe 10 edges after release, no earlier.
- **Repeat (with DEBOUNCE_BANK_REPEAT_EN):** hold noisy_in[2] high 60 cycles → rise_out[2] pulses at t0, t0+20, t0+25, t0+30, … On release the repeats stop and fall_out[2] fires once. Without the macro → a single pulse at t0 only.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch/pushbutton debouncer.
//
// Each channel runs a 2-flop synchroniser, a debounce counter, a clean level
// register and edge strobes. Channels share no state.
//
// Optional hold-to-repeat: define DEBOUNCE_BANK_REPEAT_EN to get extra
// rise_out strobes while a channel is held high (first after REPEAT_DELAY
// cycles, then every REPEAT_PERIOD cycles). Without the macro no repeat
// logic is built and the REPEAT_* parameters are ignored.
//
// Ports:
//   clock_in   system clock
//   reset_in   asynchronous, active-high reset
//   noisy_in   [CHANNELS] raw asynchronous inputs
//   clean_out  [CHANNELS] debounced levels
//   rise_out   [CHANNELS] one-cycle strobe on accepted 0->1 (and repeats)
//   fall_out   [CHANNELS] one-cycle strobe on accepted 1->0
//   any_out    registered OR of clean_out

// Single channel: synchroniser, debounce counter, level register, strobes.
// clean_nxt exposes the level being registered this cycle so the bank can
// register its OR in the same cycle as clean changes.
module debounce_lane #(
   parameter int DB_COUNT      = 1_000_000,
   parameter int CNT_W         = $clog2(DB_COUNT + 1),
   parameter int REPEAT_DELAY  = 32_500_000,
   parameter int REPEAT_PERIOD = 6_500_000
) (
   input  logic clock_in,
   input  logic reset_in,
   input  logic noisy,
   output logic clean,
   output logic clean_nxt,
   output logic rise,
   output logic fall
);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;
   logic             mismatch;
   logic             flip;
   logic             rep_fire;

   // The flip happens on the cycle the count would reach DB_COUNT, so the
   // counter itself tops out at DB_COUNT-1.
   always_comb begin
      mismatch  = (s2 != clean);
      flip      = mismatch && (cnt == CNT_W'(DB_COUNT - 1));
      clean_nxt = flip ? s2 : clean;
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1    <= noisy;
         s2    <= s1;
         cnt   <= (!mismatch || flip) ? '0 : cnt + CNT_W'(1);
         clean <= clean_nxt;
         rise  <= (flip & s2) | rep_fire;
         fall  <= flip & ~s2;
      end
   end

`ifdef DEBOUNCE_BANK_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_phase;   // 0: waiting for first repeat, 1: periodic
   logic [RW-1:0] rep_tgt;

   // rep_cnt is 0 on the cycle of the accepted rise and counts cycles since
   // the last strobe; a falling flip wins over a coincident repeat.
   always_comb begin
      rep_tgt  = rep_phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
      rep_fire = clean && !flip && ((rep_cnt + RW'(1)) == rep_tgt);
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (!clean || flip) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b1;
      end else begin
         rep_cnt   <= rep_cnt + RW'(1);
      end
   end
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rep_fire       = 1'b0;
`endif

endmodule

module debounce_bank #(
   parameter int CHANNELS      = 5,
   parameter int DB_COUNT      = 1_000_000,
   parameter int REPEAT_DELAY  = 32_500_000,
   parameter int REPEAT_PERIOD = 6_500_000,
   parameter int CNT_W         = $clog2(DB_COUNT + 1)
) (
   input  logic                clock_in,
   input  logic                reset_in,
   input  logic [CHANNELS-1:0] noisy_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_out,
   output logic [CHANNELS-1:0] fall_out,
   output logic                any_out
);

   logic [CHANNELS-1:0] clean_nxt;

   debounce_lane #(
      .DB_COUNT      (DB_COUNT),
      .CNT_W         (CNT_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_lane [CHANNELS-1:0] (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .noisy     (noisy_in),
      .clean     (clean_out),
      .clean_nxt (clean_nxt),
      .rise      (rise_out),
      .fall      (fall_out)
   );

   // OR of the next clean levels so any_out moves with clean_out.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) any_out <= 1'b0;
      else          any_out <= |clean_nxt;
   end

endmodule
